// File: rtl/decompressor_pkg.sv
// decompressor_pkg: shared definitions for the zero-flag decompressor.
// FSM encoding, token lengths, flag values and the last-word length helper.
package decompressor_pkg;

    localparam int DEF_N = 16;
    localparam int DEF_W = 64;

    localparam int TOK_ZERO_LEN = 1;
    localparam int TOK_LIT_LEN  = DEF_N + 1;

    // Flag bit values, identical on the compressor side
    localparam logic FLAG_ZERO = 1'b0;
    localparam logic FLAG_LIT  = 1'b1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        RUN   = S_RUN,
        DRAIN = S_DRAIN
    } state_t;

    // Valid bit count of a last word: 0 encodes a full 64-bit word
    function automatic logic [6:0] last_len(input logic [5:0] b);
        return (b == 6'd0) ? 7'd64 : {1'b0, b};
    endfunction

endpackage

// File: rtl/decompressor_bit_buffer.sv
// decompressor_bit_buffer: 2W-bit MSB-aligned shift buffer (bit_buffer).
// Ports: clk, rst, app_en/app_word/app_len (append), consume (bits
// removed from the head), flush, view/view_fill (buffer with the word
// being appended this cycle merged in), fill (registered bit count).
module decompressor_bit_buffer #(
    parameter int W  = 64,
    parameter int FW = $clog2(2 * W + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           app_en,
    input  logic [W-1:0]   app_word,
    input  logic [FW-1:0]  app_len,
    input  logic [FW-1:0]  consume,
    input  logic           flush,
    output logic [2*W-1:0] view,
    output logic [FW-1:0]  view_fill,
    output logic [FW-1:0]  fill
);

    logic [2*W-1:0] bits_q;
    logic [W-1:0]   keep;
    logic [2*W-1:0] word_al;

    // Bits past app_len are masked off so they never pollute later
    // appends; bits below fill in bits_q are always zero.
    always_comb begin
        keep      = '1;
        word_al   = '0;
        view      = bits_q;
        view_fill = fill;
        if (app_en) begin
            keep      = {W{1'b1}} << (FW'(W) - app_len);
            word_al   = {app_word & keep, {W{1'b0}}} >> fill;
            view      = bits_q | word_al;
            view_fill = fill + app_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            bits_q <= '0;
            fill   <= '0;
        end else begin
            bits_q <= view << consume;
            fill   <= view_fill - consume;
        end
    end

endmodule

// File: rtl/decompressor.sv
// decompressor: expands a zero-flag token stream ('0' = zero word,
// '1'+N-bit literal) packed in W-bit words into N-bit data words.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_last/in_bits/
// in_ready input stream; out_data/out_valid/out_last/out_ready output
// stream; err (sticky truncation flag); frame_done (1-cycle pulse).
// Option DECOMP_STATS_EN adds zero_cnt/lit_cnt per-frame token counters.
module decompressor
    import decompressor_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic [5:0]   in_bits,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready,
    output logic         err,
    output logic         frame_done
`ifdef DECOMP_STATS_EN
    ,
    output logic [15:0]  zero_cnt,
    output logic [15:0]  lit_cnt
`endif
);

    localparam int FW = $clog2(2 * W + 1);
    localparam logic [FW-1:0] LIT_LEN  = FW'(N + 1);
    localparam logic [FW-1:0] ZERO_LEN = FW'(TOK_ZERO_LEN);

    state_t state_q, state_d;

    logic [FW-1:0]  fill, view_fill, app_len, consume;
    logic [2*W-1:0] view;
    logic [N-1:0]   tok;
    logic acc, acc_last, start, can_emit, head;
    logic emit_zero, emit_lit, emit, ending, trunc;

    assign in_ready = (state_q != DRAIN) && (fill <= FW'(W));
    assign acc      = in_valid && in_ready;
    assign acc_last = acc && in_last;
    assign start    = acc && (state_q == IDLE);
    assign app_len  = in_last ? FW'(last_len(in_bits)) : FW'(W);

    decompressor_bit_buffer #(.W(W), .FW(FW)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .app_en    (acc),
        .app_word  (in_data),
        .app_len   (app_len),
        .consume   (consume),
        .flush     (trunc),
        .view      (view),
        .view_fill (view_fill),
        .fill      (fill)
    );

    // Decode works on the merged view so a word accepted this cycle can
    // complete a token immediately (one-cycle latency to out_valid).
    always_comb begin
        head      = view[2*W-1];
        tok       = view[2*W-2 -: N];
        can_emit  = !out_valid || out_ready;
        emit_zero = can_emit && (head == FLAG_ZERO) && (view_fill >= ZERO_LEN);
        emit_lit  = can_emit && (head == FLAG_LIT) && (view_fill >= LIT_LEN);
        emit      = emit_zero || emit_lit;
        consume   = emit_lit ? LIT_LEN : (emit_zero ? ZERO_LEN : '0);
        // No more input can arrive in DRAIN, so a short literal is dead
        trunc     = (state_q == DRAIN) && (fill != '0) &&
                    (head == FLAG_LIT) && (fill < LIT_LEN);
        ending    = ((state_q == DRAIN) || acc_last) &&
                    (view_fill == consume) && !trunc;
    end

    always_comb begin
        state_d = state_q;
        if (trunc || ending) begin
            state_d = IDLE;
        end else if (acc_last) begin
            state_d = DRAIN;
        end else if (start) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            err        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= trunc || ending;
            if (emit) begin
                out_data  <= emit_lit ? tok : '0;
                out_valid <= 1'b1;
                out_last  <= ending;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (start) begin
                err <= 1'b0;
            end else if (trunc) begin
                err <= 1'b1;
            end
        end
    end

`ifdef DECOMP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_cnt <= '0;
            lit_cnt  <= '0;
        end else if (start) begin
            zero_cnt <= {15'd0, emit_zero};
            lit_cnt  <= {15'd0, emit_lit};
        end else begin
            if (emit_zero && (zero_cnt != 16'hFFFF)) begin
                zero_cnt <= zero_cnt + 16'd1;
            end
            if (emit_lit && (lit_cnt != 16'hFFFF)) begin
                lit_cnt <= lit_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decompressor.sv
// tb_decompressor: table vectors, hand sequences and random frames
// checked against a bit-queue token parser.
module tb_decompressor;
    import decompressor_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic        in_valid, in_last, in_ready;
    logic [5:0]  in_bits;
    logic [15:0] out_data;
    logic        out_valid, out_last, out_ready, err, frame_done;
`ifdef DECOMP_STATS_EN
    logic [15:0] zero_cnt, lit_cnt;
`endif

    always #5 clk = ~clk;

    decompressor dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_bits    (in_bits),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .err        (err),
        .frame_done (frame_done)
`ifdef DECOMP_STATS_EN
        ,
        .zero_cnt   (zero_cnt),
        .lit_cnt    (lit_cnt)
`endif
    );

    typedef struct {
        logic [63:0] w0;
        logic [63:0] w1;
        int          nw;
        logic [5:0]  bits;
        int          rmode;
        int          hold;
        int          exp_n;
        logic [15:0] exp_first;
        logic [15:0] exp_final;
        logic        exp_err;
    } vec_t;

    localparam int NV = 9;
    localparam int BUDGET = 3000;

    vec_t        tv[NV];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [63:0] wq[$];
    logic [5:0]  bq[$];
    logic [15:0] got_d[$];
    logic        got_l[$];
    logic [15:0] exp_d[$];
    logic        exp_l[$];
    logic        exp_err;
    int          exp_z, exp_lc;
    int          done_cnt;
    bit          s[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic run_frame(input int rmode, input int hold_idx,
                             input int hold_until, output int n_hold);
        int wi, cyc, nw;
        logic stall;
        logic [15:0] pd;
        wi = 0; cyc = 0; nw = wq.size();
        stall = 0; pd = '0; n_hold = -1;
        got_d.delete(); got_l.delete(); done_cnt = 0;
        forever begin
            @(negedge clk);
            if (frame_done) done_cnt++;
            if (stall) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", 32'(out_data), 32'(pd));
            end
            if (done_cnt > 0 && wi == nw && !out_valid) break;
            if (cyc >= BUDGET) begin
                n_vec++; n_bad++;
                $display("FAIL timeout: got %0d cycles, expected < %0d",
                         cyc, BUDGET);
                break;
            end
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
            end
            stall = out_valid && !out_ready;
            pd = out_data;
            if (cyc == hold_until) n_hold = got_d.size();
            in_valid = (wi < nw) &&
                       !(hold_idx >= 0 && wi >= hold_idx && cyc < hold_until);
            if (in_valid) begin
                in_data = wq[wi];
                in_bits = bq[wi];
                in_last = (wi == nw - 1);
            end else begin
                in_data = '0;
                in_bits = '0;
                in_last = 1'b0;
            end
            if (in_valid && in_ready) wi++;
            cyc++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
    endtask

    // Reference: walk the bit stream token by token
    task automatic model();
        int i;
        logic [15:0] v;
        exp_d.delete(); exp_l.delete();
        exp_err = 0; exp_z = 0; exp_lc = 0; i = 0;
        while (i < s.size()) begin
            if (s[i] == 1'b0) begin
                exp_d.push_back(16'h0); exp_l.push_back(1'b0);
                exp_z++; i++;
            end else if (i + 17 <= s.size()) begin
                v = '0;
                for (int b = 0; b < 16; b++) v = {v[14:0], s[i + 1 + b]};
                exp_d.push_back(v); exp_l.push_back(1'b0);
                exp_lc++; i += 17;
            end else begin
                exp_err = 1'b1;
                break;
            end
        end
        if (!exp_err && exp_l.size() > 0) exp_l[exp_l.size() - 1] = 1'b1;
    endtask

    // Pack the stream MSB-first; unused tail bits are random junk
    task automatic pack();
        logic [63:0] w;
        int len;
        wq.delete(); bq.delete();
        for (int p = 0; p < s.size(); p += 64) begin
            w = {32'($urandom), 32'($urandom)};
            len = s.size() - p;
            if (len > 64) len = 64;
            for (int b = 0; b < len; b++) w[63 - b] = s[p + b];
            wq.push_back(w);
            bq.push_back(6'(len));
        end
    endtask

    initial begin
        int nh, cyc, nl, ntok, k;
        logic [15:0] v, req;
        logic req_last;

        tv[0] = '{64'h8000_8000_0000_0000, 64'h0, 1, 6'd18, 0, 0,
                  2, 16'h0001, 16'h0000, 1'b0};
        tv[1] = '{64'h0, 64'h0, 2, 6'd0, 0, 0,
                  128, 16'h0000, 16'h0000, 1'b0};
        tv[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hF000_0000_0000_0000, 2, 6'd4,
                  0, 12, 4, 16'hFFFF, 16'hFFFF, 1'b0};
        tv[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hF000_0000_0000_0000, 2, 6'd4,
                  1, 0, 4, 16'hFFFF, 16'hFFFF, 1'b0};
        tv[4] = '{64'hC000_0000_0000_0000, 64'h0, 1, 6'd10, 0, 0,
                  0, 16'h0, 16'h0, 1'b1};
        tv[5] = '{64'h0, 64'h0, 1, 6'd1, 0, 0,
                  1, 16'h0000, 16'h0000, 1'b0};
        tv[6] = '{64'hD2E1_8000_0000_0000, 64'h0, 1, 6'd17, 0, 0,
                  1, 16'hA5C3, 16'hA5C3, 1'b0};
        tv[7] = '{64'hFFFF_0000_0000_0000, 64'h0, 1, 6'd16, 0, 0,
                  0, 16'h0, 16'h0, 1'b1};
        tv[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 6'd0, 0, 0,
                  3, 16'hFFFF, 16'hFFFF, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; in_bits = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        rst = 1'b0;

        // Stall the output so the buffer fills past one word
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = '0; in_last = 1'b0; in_bits = '0;
        @(negedge clk);
        chk("ready_after_w0", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ready_fill_gt_w", 32'(in_ready), 0);
        chk("stalled_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        cyc = 0;
        while (dut.u_buf.fill != 8'd40 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("fill_at_40", 32'(dut.u_buf.fill), 40);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_last", 32'(out_last), 0);
        chk("midrst_fill", 32'(dut.u_buf.fill), 0);
        chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
        chk("midrst_err", 32'(err), 0);

        for (int i = 0; i < NV; i++) begin
            wq.delete(); bq.delete();
            wq.push_back(tv[i].w0);
            bq.push_back(tv[i].nw == 1 ? tv[i].bits : 6'($urandom));
            if (tv[i].nw == 2) begin
                wq.push_back(tv[i].w1);
                bq.push_back(tv[i].bits);
            end
            run_frame(tv[i].rmode, tv[i].hold > 0 ? 1 : -1, tv[i].hold, nh);
            chk($sformatf("v%0d_count", i), got_d.size(), tv[i].exp_n);
            if (tv[i].hold > 0) chk($sformatf("v%0d_early", i), nh, 3);
            nl = 0;
            for (int j = 0; j < got_d.size(); j++) begin
                req = (j == got_d.size() - 1) ? tv[i].exp_final
                                              : tv[i].exp_first;
                chk($sformatf("v%0d_data%0d", i, j), 32'(got_d[j]), 32'(req));
                if (got_l[j]) nl++;
            end
            req_last = (tv[i].exp_n > 0) && !tv[i].exp_err;
            chk($sformatf("v%0d_nlast", i), nl, 32'(req_last));
            if (got_l.size() > 0)
                chk($sformatf("v%0d_lastpos", i),
                    32'(got_l[got_l.size() - 1]), 32'(req_last));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(tv[i].exp_err));
            chk($sformatf("v%0d_done", i), done_cnt, 1);
        end

        for (int f = 0; f < 30; f++) begin
            s.delete();
            ntok = $urandom_range(1, 60);
            for (int t = 0; t < ntok; t++) begin
                if ($urandom_range(0, 1) == 0) begin
                    s.push_back(1'b0);
                end else begin
                    v = 16'($urandom);
                    s.push_back(1'b1);
                    for (int b = 15; b >= 0; b--) s.push_back(v[b]);
                end
            end
            if ($urandom_range(0, 4) == 0) begin
                s.push_back(1'b1);
                k = $urandom_range(0, 15);
                repeat (k) s.push_back(1'($urandom_range(0, 1)));
            end
            pack();
            model();
            run_frame($urandom_range(0, 2), -1, 0, nh);
            chk($sformatf("r%0d_count", f), got_d.size(), exp_d.size());
            for (int j = 0; j < got_d.size() && j < exp_d.size(); j++) begin
                chk($sformatf("r%0d_data%0d", f, j),
                    32'(got_d[j]), 32'(exp_d[j]));
                chk($sformatf("r%0d_last%0d", f, j),
                    32'(got_l[j]), 32'(exp_l[j]));
            end
            chk($sformatf("r%0d_err", f), 32'(err), 32'(exp_err));
            chk($sformatf("r%0d_done", f), done_cnt, 1);
`ifdef DECOMP_STATS_EN
            chk($sformatf("r%0d_zcnt", f), 32'(zero_cnt), exp_z);
            chk($sformatf("r%0d_lcnt", f), 32'(lit_cnt), exp_lc);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
